// File: rtl/data_bus_bridge.sv
// -----------------------------------------------------------------------------
// data_bus_bridge
//   Memory-stage data bus for a small pipelined core: a word-addressed data RAM
//   plus a handful of memory-mapped peripherals (GPIO and an optional timer).
//   Reads are combinational (zero wait states); writes land on the rising edge.
//
//   Optional feature: define DATA_BUS_BRIDGE_TIMER_EN to build the timer
//   (TIMER_CNT / TIMER_CMP / TIMER_CTRL at 0x1008..0x1010 and irq). Without it
//   those addresses read 0, ignore writes, and irq is tied low.
//
// Ports
//   clk         in   clock, all state updates on the rising edge
//   reset       in   asynchronous active-low reset
//   MemWriteM   in   store strobe
//   ALUResultM  in   byte address (bits [1:0] ignored)
//   WriteDataM  in   store data
//   ReadDataM   out  load data, same cycle as ALUResultM
//   gpio_in     in   asynchronous external inputs (synchronised internally)
//   gpio_out    out  registered GPIO outputs
//   irq         out  timer interrupt level (TIMER_CTRL.pending)
// -----------------------------------------------------------------------------
module data_bus_bridge #(
    parameter int RAM_WORDS = 64,
    parameter int GPIO_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemWriteM,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    output logic [31:0]       ReadDataM,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              irq
);

    localparam int AW = $clog2(RAM_WORDS);

    // Word addresses (byte address >> 2) of the MMIO registers
    localparam logic [29:0] WA_GPIO_OUT = 30'h400;
    localparam logic [29:0] WA_GPIO_IN  = 30'h401;
`ifdef DATA_BUS_BRIDGE_TIMER_EN
    localparam logic [29:0] WA_TCNT     = 30'h402;
    localparam logic [29:0] WA_TCMP     = 30'h403;
    localparam logic [29:0] WA_TCTRL    = 30'h404;
`endif

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    logic [29:0]   w_word;
    logic          w_ram_hit;
    logic [AW-1:0] w_ram_idx;
    logic          w_unused_addr_lsb;

    assign w_word            = ALUResultM[31:2];
    assign w_ram_hit         = (w_word[29:AW] == '0);
    assign w_ram_idx         = w_word[AW-1:0];
    // Byte offset within the word is don't-care: all accesses are whole-word.
    assign w_unused_addr_lsb = ^ALUResultM[1:0];

    // -------------------------------------------------------------------------
    // Data RAM (no reset: contents undefined after power-up)
    // -------------------------------------------------------------------------
    logic [31:0] r_mem [RAM_WORDS];

    always_ff @(posedge clk) begin
        if (MemWriteM && w_ram_hit) begin
            r_mem[w_ram_idx] <= WriteDataM;
        end
    end

    // -------------------------------------------------------------------------
    // GPIO: output register and two-flop input synchroniser
    // -------------------------------------------------------------------------
    logic [GPIO_W-1:0] r_gpio_out;
    logic [GPIO_W-1:0] r_sync1;
    logic [GPIO_W-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gpio_out <= '0;
            r_sync1    <= '0;
            r_sync2    <= '0;
        end else begin
            r_sync1 <= gpio_in;
            r_sync2 <= r_sync1;
            if (MemWriteM && (w_word == WA_GPIO_OUT)) begin
                r_gpio_out <= WriteDataM[GPIO_W-1:0];
            end
        end
    end

    assign gpio_out = r_gpio_out;

`ifdef DATA_BUS_BRIDGE_TIMER_EN
    // -------------------------------------------------------------------------
    // Timer
    // -------------------------------------------------------------------------
    logic [31:0] r_cnt;
    logic [31:0] r_cmp;
    logic        r_en;
    logic        r_ar;
    logic        r_pend;

    logic [31:0] w_cnt_nxt;
    logic [31:0] w_cmp_nxt;
    logic        w_en_nxt;
    logic        w_ar_nxt;
    logic        w_pend_nxt;
    logic        w_match;

    always_comb begin
        w_match    = r_en && (r_cnt == r_cmp);
        w_cnt_nxt  = r_cnt;
        w_cmp_nxt  = r_cmp;
        w_en_nxt   = r_en;
        w_ar_nxt   = r_ar;
        w_pend_nxt = r_pend;

        // Hardware update first; software writes below take priority.
        if (w_match) begin
            w_pend_nxt = 1'b1;
            if (r_ar) begin
                w_cnt_nxt = '0;
            end else begin
                w_en_nxt = 1'b0;
            end
        end else if (r_en) begin
            w_cnt_nxt = r_cnt + 32'd1;
        end

        if (MemWriteM) begin
            if (w_word == WA_TCNT) begin
                w_cnt_nxt = WriteDataM;
            end
            if (w_word == WA_TCMP) begin
                w_cmp_nxt = WriteDataM;
            end
            if (w_word == WA_TCTRL) begin
                w_en_nxt = WriteDataM[0];
                w_ar_nxt = WriteDataM[1];
                // W1C loses against a simultaneous match.
                if (WriteDataM[2] && !w_match) begin
                    w_pend_nxt = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_cmp  <= '1;
            r_en   <= 1'b0;
            r_ar   <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_cmp  <= w_cmp_nxt;
            r_en   <= w_en_nxt;
            r_ar   <= w_ar_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign irq = r_pend;
`else
    assign irq = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Combinational read mux
    // -------------------------------------------------------------------------
    always_comb begin
        ReadDataM = '0;
        if (w_ram_hit) begin
            ReadDataM = r_mem[w_ram_idx];
        end else begin
            case (w_word)
                WA_GPIO_OUT: ReadDataM[GPIO_W-1:0] = r_gpio_out;
                WA_GPIO_IN:  ReadDataM[GPIO_W-1:0] = r_sync2;
`ifdef DATA_BUS_BRIDGE_TIMER_EN
                WA_TCNT:     ReadDataM = r_cnt;
                WA_TCMP:     ReadDataM = r_cmp;
                WA_TCTRL:    ReadDataM[2:0] = {r_pend, r_ar, r_en};
`endif
                default:     ReadDataM = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_data_bus_bridge
//   Self-checking bench for data_bus_bridge. A behavioural model (RAM array with
//   written-flags, GPIO input history, timer rules) predicts every output; one
//   compare process checks ReadDataM, gpio_out and irq on each falling edge.
//   Directed sequences with literal expectations pin the model, followed by a
//   randomized phase. Honours DATA_BUS_BRIDGE_TIMER_EN like the design.
// -----------------------------------------------------------------------------
module tb_data_bus_bridge;

    localparam int RAM_WORDS = 64;
    localparam int GPIO_W    = 8;

    localparam logic [31:0] A_GOUT = 32'h1000;
    localparam logic [31:0] A_GIN  = 32'h1004;
    localparam logic [31:0] A_CNT  = 32'h1008;
    localparam logic [31:0] A_CMP  = 32'h100C;
    localparam logic [31:0] A_CTRL = 32'h1010;

    logic              clk        = 1'b0;
    logic              reset      = 1'b1;
    logic              MemWriteM  = 1'b0;
    logic [31:0]       ALUResultM = '0;
    logic [31:0]       WriteDataM = '0;
    logic [31:0]       ReadDataM;
    logic [GPIO_W-1:0] gpio_in    = '0;
    logic [GPIO_W-1:0] gpio_out;
    logic              irq;

    int n_checks = 0;
    int n_errors = 0;

    data_bus_bridge #(
        .RAM_WORDS (RAM_WORDS),
        .GPIO_W    (GPIO_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .gpio_in    (gpio_in),
        .gpio_out   (gpio_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Behavioural model
    // -------------------------------------------------------------------------
    logic [31:0]       m_ram   [RAM_WORDS];
    bit                m_valid [RAM_WORDS];
    logic [GPIO_W-1:0] m_gpio_out;
    logic [GPIO_W-1:0] m_seen_1ago;   // gpio_in sampled one edge ago
    logic [GPIO_W-1:0] m_seen_2ago;   // gpio_in sampled two edges ago
    logic [29:0]       m_wa;
`ifdef DATA_BUS_BRIDGE_TIMER_EN
    logic [31:0] m_cnt, m_cmp, t_cnt, t_cmp;
    bit          m_en, m_ar, m_pend, t_en, t_ar, t_pend, t_hit;
`endif

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_gpio_out  <= '0;
            m_seen_1ago <= '0;
            m_seen_2ago <= '0;
`ifdef DATA_BUS_BRIDGE_TIMER_EN
            m_cnt  <= 32'd0;
            m_cmp  <= 32'hFFFF_FFFF;
            m_en   <= 1'b0;
            m_ar   <= 1'b0;
            m_pend <= 1'b0;
`endif
        end else begin
            m_seen_1ago <= gpio_in;
            m_seen_2ago <= m_seen_1ago;
            m_wa = ALUResultM[31:2];
            if (MemWriteM && m_wa < RAM_WORDS) begin
                m_ram[int'(m_wa)]   <= WriteDataM;
                m_valid[int'(m_wa)] <= 1'b1;
            end
            if (MemWriteM && ALUResultM[31:2] == A_GOUT[31:2])
                m_gpio_out <= WriteDataM[GPIO_W-1:0];
`ifdef DATA_BUS_BRIDGE_TIMER_EN
            t_hit  = m_en && (m_cnt == m_cmp);
            t_cnt  = m_cnt; t_cmp = m_cmp; t_en = m_en; t_ar = m_ar; t_pend = m_pend;
            if (t_hit) begin
                t_pend = 1'b1;
                if (m_ar) t_cnt = 32'd0;
                else      t_en  = 1'b0;
            end else if (m_en) begin
                t_cnt = m_cnt + 32'd1;
            end
            if (MemWriteM && ALUResultM[31:2] == A_CNT[31:2]) t_cnt = WriteDataM;
            if (MemWriteM && ALUResultM[31:2] == A_CMP[31:2]) t_cmp = WriteDataM;
            if (MemWriteM && ALUResultM[31:2] == A_CTRL[31:2]) begin
                t_en = WriteDataM[0];
                t_ar = WriteDataM[1];
                if (WriteDataM[2] && !t_hit) t_pend = 1'b0;
            end
            m_cnt <= t_cnt; m_cmp <= t_cmp; m_en <= t_en; m_ar <= t_ar; m_pend <= t_pend;
`endif
        end
    end

    function automatic logic [31:0] m_read(input logic [31:0] a, output bit known);
        logic [29:0] w;
        w      = a[31:2];
        known  = 1'b1;
        m_read = 32'd0;
        if (w < RAM_WORDS) begin
            known  = m_valid[int'(w)];
            m_read = m_ram[int'(w)];
        end else if (w == A_GOUT[31:2]) m_read = 32'(m_gpio_out);
        else if (w == A_GIN[31:2])      m_read = 32'(m_seen_2ago);
`ifdef DATA_BUS_BRIDGE_TIMER_EN
        else if (w == A_CNT[31:2])      m_read = m_cnt;
        else if (w == A_CMP[31:2])      m_read = m_cmp;
        else if (w == A_CTRL[31:2])     m_read = {29'd0, m_pend, m_ar, m_en};
`endif
    endfunction

    function automatic logic m_irq();
`ifdef DATA_BUS_BRIDGE_TIMER_EN
        return m_pend;
`else
        return 1'b0;
`endif
    endfunction

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [31:0] c_exp;
    bit          c_known;
    always @(negedge clk) begin
        if (reset) begin
            c_exp = m_read(ALUResultM, c_known);
            if (c_known) check("model_rdata", ReadDataM, c_exp);
            check("model_gpio_out", 32'(gpio_out), 32'(m_gpio_out));
            check("model_irq", 32'(irq), 32'(m_irq()));
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // -------------------------------------------------------------------------
    task automatic drive(input bit we, input logic [31:0] a, input logic [31:0] d);
        MemWriteM  = we;
        ALUResultM = a;
        WriteDataM = d;
        @(posedge clk); #1;
        MemWriteM  = 1'b0;
    endtask

    task automatic idle(input int n);
        MemWriteM = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWriteM  = 1'b0;
        ALUResultM = a;
        #1;
        check(name, ReadDataM, exp);
    endtask

    int unsigned sel;
    logic [31:0] ra, rd;

    initial begin
        #1 reset = 1'b0;
        #2;
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        peek("rst_gout_rd", A_GOUT, 32'h0);
`ifdef DATA_BUS_BRIDGE_TIMER_EN
        peek("rst_cmp_rd", A_CMP, 32'hFFFF_FFFF);
`else
        peek("rst_cmp_rd", A_CMP, 32'h0);
`endif
        #7 reset = 1'b1;             // t=12; first write lands on the edge at t=15

        // RAM
        drive(1, 32'h04, 32'hDEAD_BEEF);
        peek("ram_rd_04", 32'h04, 32'hDEAD_BEEF);
        peek("ram_rd_07", 32'h07, 32'hDEAD_BEEF);
        idle(1);
        peek("unmapped_800", 32'h0800, 32'h0);
        drive(1, 32'h0800, 32'h1234_5678);
        peek("ram_after_unmapped_wr", 32'h04, 32'hDEAD_BEEF);
        drive(1, 32'hFC, 32'hCAFE_F00D);
        peek("ram_last_word", 32'hFC, 32'hCAFE_F00D);
        peek("ram_past_end", 32'h100, 32'h0);
        drive(1, 32'h08, 32'h1111_1111);
        drive(1, 32'h08, 32'h2222_2222);   // read during this write sees old value
        peek("ram_rewrite", 32'h08, 32'h2222_2222);

        // GPIO
        drive(1, A_GOUT, 32'h0000_00A5);
        check("gpio_out_a5", 32'(gpio_out), 32'hA5);
        drive(1, A_GOUT, 32'hFFFF_FF5A);
        peek("gpio_out_upper0", A_GOUT, 32'h5A);
        gpio_in = 8'h3C;
        peek("gpio_in_0cyc", A_GIN, 32'h0);
        idle(1);
        peek("gpio_in_1cyc", A_GIN, 32'h0);
        idle(1);
        peek("gpio_in_2cyc", A_GIN, 32'h3C);
        drive(1, A_GIN, 32'hFF);
        peek("gpio_in_ro", A_GIN, 32'h3C);

`ifdef DATA_BUS_BRIDGE_TIMER_EN
        // Autoreload: period 6
        drive(1, A_CTRL, 32'h4);
        drive(1, A_CMP, 32'd5);
        drive(1, A_CNT, 32'd0);
        drive(1, A_CTRL, 32'h3);
        idle(5);
        peek("ar_cnt5", A_CNT, 32'd5);
        check("ar_irq_before", 32'(irq), 32'd0);
        idle(1);
        check("ar_irq_rise", 32'(irq), 32'd1);
        peek("ar_cnt_restart", A_CNT, 32'd0);
        drive(1, A_CTRL, 32'h7);
        check("ar_w1c", 32'(irq), 32'd0);
        idle(4);
        check("ar_irq_before2", 32'(irq), 32'd0);
        idle(1);
        check("ar_irq_rise2", 32'(irq), 32'd1);
        // Match and W1C on the same edge
        drive(1, A_CTRL, 32'h7);
        check("w1c_clear", 32'(irq), 32'd0);
        idle(4);
        drive(1, A_CTRL, 32'h7);
        check("match_beats_w1c", 32'(irq), 32'd1);
        peek("match_beats_w1c_cnt", A_CNT, 32'd0);

        // One-shot
        drive(1, A_CTRL, 32'h4);
        drive(1, A_CNT, 32'd0);
        drive(1, A_CMP, 32'd3);
        drive(1, A_CTRL, 32'h1);
        idle(4);
        peek("os_cnt_hold", A_CNT, 32'd3);
        check("os_irq", 32'(irq), 32'd1);
        peek("os_ctrl", A_CTRL, 32'h4);
        idle(2);
        peek("os_cnt_still", A_CNT, 32'd3);
        drive(1, A_CTRL, 32'h4);
        check("os_irq_clear", 32'(irq), 32'd0);

        // CNT write on a match edge: write wins, pending still set
        drive(1, A_CNT, 32'd10);
        drive(1, A_CMP, 32'd12);
        drive(1, A_CTRL, 32'h3);
        idle(2);
        drive(1, A_CNT, 32'd100);
        peek("cntwr_on_match", A_CNT, 32'd100);
        check("cntwr_on_match_irq", 32'(irq), 32'd1);

        // CTRL.en write overrides the one-shot auto-clear
        drive(1, A_CTRL, 32'h4);
        drive(1, A_CNT, 32'd20);
        drive(1, A_CMP, 32'd22);
        drive(1, A_CTRL, 32'h1);
        idle(2);
        drive(1, A_CTRL, 32'h1);
        peek("en_override_ctrl", A_CTRL, 32'h5);
        peek("en_override_cnt", A_CNT, 32'd22);

        // Wrap
        drive(1, A_CTRL, 32'h4);
        drive(1, A_CMP, 32'd5);
        drive(1, A_CNT, 32'hFFFF_FFFF);
        drive(1, A_CTRL, 32'h1);
        idle(1);
        peek("wrap_to_0", A_CNT, 32'd0);

        // Reset mid-count
        drive(1, A_CTRL, 32'h4);
        drive(1, A_CMP, 32'hFFFF);
        drive(1, A_CNT, 32'd0);
        drive(1, A_CTRL, 32'h1);
        idle(2);
        peek("pre_reset_cnt", A_CNT, 32'd2);
`else
        drive(1, A_CMP, 32'd5);
        drive(1, A_CNT, 32'd7);
        drive(1, A_CTRL, 32'h3);
        peek("notimer_cnt", A_CNT, 32'h0);
        peek("notimer_ctrl", A_CTRL, 32'h0);
        idle(3);
        check("notimer_irq", 32'(irq), 32'd0);
        peek("notimer_cmp", A_CMP, 32'h0);
`endif
        reset = 1'b0;
        #1;
        peek("async_rst_cnt", A_CNT, 32'h0);
        check("async_rst_irq", 32'(irq), 32'd0);
        check("async_rst_gpio", 32'(gpio_out), 32'd0);
        idle(2);
        reset = 1'b1;
        idle(3);
        check("post_rst_irq", 32'(irq), 32'd0);
        peek("post_rst_cnt", A_CNT, 32'h0);
        peek("post_rst_gin", A_GIN, 32'h3C);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 4) begin
                ra = ($urandom_range(0, RAM_WORDS - 1) << 2) | $urandom_range(0, 3);
            end else if (sel <= 7) begin
                ra = 32'h1000 + ($urandom_range(0, 4) << 2) + $urandom_range(0, 3);
            end else begin
                ra = $urandom;
                if (ra[31:2] < RAM_WORDS || (ra[31:2] >= 30'h400 && ra[31:2] <= 30'h404))
                    ra = 32'h2000 + ($urandom_range(0, 63) << 2);
            end
            rd = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            gpio_in = GPIO_W'($urandom);
            drive(($urandom_range(0, 9) < 4), ra, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
